// File: rtl/adc_capture_pkg.sv
// Shared types and constants for the ADC capture block: FSM encoding, data width
// and the slope-crossing test used by the trigger.
package adc_capture_pkg;

  localparam int ADC_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PREFILL = 3'd1,
    ST_ARMED   = 3'd2,
    ST_POST    = 3'd3,
    ST_DONE    = 3'd4
  } cap_state_e;

  function automatic logic crossed(input logic [ADC_W-1:0] prev,
                                   input logic [ADC_W-1:0] cur,
                                   input logic [ADC_W-1:0] lvl,
                                   input logic             falling);
    if (falling) return (prev >= lvl) && (cur < lvl);
    else         return (prev < lvl) && (cur >= lvl);
  endfunction

endpackage

// File: rtl/adc_capture_if.sv
// ADC pin bus plus host control/readout port of adc_capture. The master is the
// host/board side, the slave is the capture block.
interface adc_capture_if #(parameter int AddrBits = 8);
  import adc_capture_pkg::*;

  logic [ADC_W-1:0]    adc_d;
  logic                adc_c;
  logic                arm;
  logic                force_trig;
  logic [ADC_W-1:0]    trig_level;
  logic                trig_falling;
  logic                busy;
  logic                done;
  logic [AddrBits-1:0] rd_addr;
  logic [ADC_W-1:0]    rd_data;

  modport master (
    output adc_d, arm, force_trig, trig_level, trig_falling, rd_addr,
    input  adc_c, busy, done, rd_data
  );

  modport slave (
    input  adc_d, arm, force_trig, trig_level, trig_falling, rd_addr,
    output adc_c, busy, done, rd_data
  );

endinterface

// File: rtl/adc_capture_sample_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port,
// shaped so synthesis maps it onto block RAM.
module sample_ram #(
  parameter int AddrBits = 8,
  parameter int Width    = 8
) (
  input  logic                clk,
  input  logic                rst_i,
  input  logic                we_i,
  input  logic [AddrBits-1:0] waddr_i,
  input  logic [Width-1:0]    wdata_i,
  input  logic [AddrBits-1:0] raddr_i,
  output logic [Width-1:0]    rdata_o
);

  logic [Width-1:0] mem_q [2**AddrBits];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Only the output register is reset; the array itself keeps stale contents.
  always_ff @(posedge clk) begin
    if (rst_i) rdata_q <= '0;
    else       rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/adc_capture.sv
// Parallel-ADC capture: sample clock divider, level/slope trigger and a
// pre/post-trigger window stored in a ring buffer, read back oldest-first.
module adc_capture
  import adc_capture_pkg::*;
#(
  parameter int ClkDiv   = 2,
  parameter int AddrBits = 8,
  parameter int PreTrig  = 64
) (
  input  logic           clk,
  input  logic           sync_reset,
  adc_capture_if.slave   bus
);

  localparam int Depth = 2**AddrBits;
  localparam int PostN = Depth - PreTrig;
  localparam int DivW  = $clog2(ClkDiv);
  localparam logic [DivW-1:0]     DivLast  = DivW'(ClkDiv - 1);
  localparam logic [DivW-1:0]     DivHalf  = DivW'(ClkDiv / 2);
  localparam logic [AddrBits-1:0] PreLast  = AddrBits'(PreTrig - 1);
  localparam logic [AddrBits:0]   PostLast = (AddrBits+1)'(PostN - 1);

  logic [DivW-1:0]     div_q;
  logic                adc_c_q;
  logic                samp_stb;
  cap_state_e          state_q;
  logic                busy_q, done_q;
  logic [AddrBits-1:0] pre_cnt_q;
  logic [AddrBits:0]   post_cnt_q;
  logic                prev_vld_q;
  logic                force_q;
  logic [AddrBits-1:0] wptr_q, start_ptr_q;
  logic [ADC_W-1:0]    cur_q, prev_q;
  logic                wr_en, trig_hit;
  logic [AddrBits-1:0] raddr;
  logic [ADC_W-1:0]    rdata;

  // adc_c lags the count by one clk so it is a clean register output; the
  // strobe lines up with the edge on which adc_c drops.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      div_q   <= '0;
      adc_c_q <= 1'b0;
    end else begin
      div_q   <= (div_q == DivLast) ? '0 : div_q + 1'b1;
      adc_c_q <= (div_q < DivHalf);
    end
  end

  assign samp_stb = (div_q == DivHalf);
  assign wr_en    = samp_stb && (state_q inside {ST_PREFILL, ST_ARMED, ST_POST});

  // The sample being captured this strobe is adc_d; the one before it is cur_q.
  assign trig_hit = samp_stb &&
                    ((prev_vld_q && crossed(cur_q, bus.adc_d, bus.trig_level, bus.trig_falling)) ||
                     force_q || bus.force_trig);

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      prev_vld_q  <= 1'b0;
      force_q     <= 1'b0;
      wptr_q      <= '0;
      start_ptr_q <= '0;
      cur_q       <= '0;
      prev_q      <= '0;
    end else begin
      if (samp_stb) begin
        cur_q  <= bus.adc_d;
        prev_q <= cur_q;
      end
      if (wr_en) wptr_q <= wptr_q + 1'b1;
      force_q <= (state_q == ST_ARMED) && !samp_stb && (force_q || bus.force_trig);

      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.arm) begin
            state_q    <= (PreTrig == 0) ? ST_ARMED : ST_PREFILL;
            pre_cnt_q  <= '0;
            prev_vld_q <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
          end
        end
        ST_PREFILL: begin
          if (samp_stb) begin
            prev_vld_q <= 1'b1;
            pre_cnt_q  <= pre_cnt_q + 1'b1;
            if (pre_cnt_q == PreLast) state_q <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (samp_stb) begin
            prev_vld_q <= 1'b1;
            if (trig_hit) begin
              post_cnt_q <= (AddrBits+1)'(1);
              if (PostN == 1) begin
                state_q     <= ST_DONE;
                busy_q      <= 1'b0;
                done_q      <= 1'b1;
                start_ptr_q <= wptr_q + 1'b1;
              end else begin
                state_q <= ST_POST;
              end
            end
          end
        end
        ST_POST: begin
          if (samp_stb) begin
            post_cnt_q <= post_cnt_q + 1'b1;
            if (post_cnt_q == PostLast) begin
              state_q     <= ST_DONE;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              start_ptr_q <= wptr_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign raddr = start_ptr_q + bus.rd_addr;

  sample_ram #(
    .AddrBits (AddrBits),
    .Width    (ADC_W)
  ) u_ram (
    .clk     (clk),
    .rst_i   (sync_reset),
    .we_i    (wr_en),
    .waddr_i (wptr_q),
    .wdata_i (bus.adc_d),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  assign bus.adc_c   = adc_c_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rd_data = rdata;

endmodule
